// File: rtl/instruction_fetch_memory.sv
// -----------------------------------------------------------------------------
// instruction_fetch_memory
//
// Word-addressed instruction store with a valid/ready fetch port and a
// side-band program-load write port. Each fetch is read on the accepting edge
// and parked in a 2-entry response FIFO, so up to two responses can be
// outstanding. Responses are returned in request order. Illegal addresses
// (misaligned or past DEPTH) produce a response with Instruction = 0 and
// AddrFault = 1.
//
// Ports
//   Clk          rising-edge clock
//   Rst          synchronous active-low reset (memory contents are kept)
//   ReqValid     fetch request present
//   ReqReady     request can be accepted this cycle
//   Address      byte address of the fetch
//   RespValid    response present
//   RespReady    consumer takes the response
//   Instruction  fetched word (0 for a faulting response)
//   AddrFault    response belongs to an illegal address
//   LoadEn       program-load write strobe
//   LoadAddr     program-load byte address
//   LoadData     program-load word
// -----------------------------------------------------------------------------
module instruction_fetch_memory #(
    parameter int DEPTH     = 128,
    parameter int WIDTH     = 32,
    parameter int INIT_MODE = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [31:0]      Address,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] Instruction,
    output logic             AddrFault,
    input  logic             LoadEn,
    input  logic [31:0]      LoadAddr,
    input  logic [WIDTH-1:0] LoadData
);

    localparam int IDX_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]    w_mem [DEPTH];
    logic [IDX_BITS-1:0] w_req_idx;
    logic [IDX_BITS-1:0] w_load_idx;
    logic                w_req_ok;
    logic                w_load_ok;
    logic                w_wr_en;
    logic                w_accept;
    logic                w_pop;
    logic                w_tail;
    logic [WIDTH-1:0]    w_rd_data;

    logic [WIDTH-1:0]    r_data [2];
    logic [1:0]          r_fault;
    logic                r_head;
    logic [1:0]          r_count;

    assign w_req_idx  = Address[IDX_BITS+1:2];
    assign w_load_idx = LoadAddr[IDX_BITS+1:2];

    // Range check uses the full word address, so aliases above DEPTH fault
    // instead of wrapping onto a low word.
    assign w_req_ok  = (Address[1:0] == 2'b00)  && ({2'b00, Address[31:2]}  < 32'(DEPTH));
    assign w_load_ok = (LoadAddr[1:0] == 2'b00) && ({2'b00, LoadAddr[31:2]} < 32'(DEPTH));
    assign w_wr_en   = Rst && LoadEn && w_load_ok;

    assign w_accept = ReqValid && ReqReady;
    assign w_pop    = RespValid && RespReady;

    // Tail slot of the 2-deep ring; with count 0 it equals the head.
    assign w_tail = r_head ^ r_count[0];

    // Same-cycle load to the requested word wins over the stored value.
    always_comb begin
        w_rd_data = '0;
        if (w_req_ok) begin
            if (w_wr_en && (w_load_idx == w_req_idx)) begin
                w_rd_data = LoadData;
            end else begin
                w_rd_data = w_mem[w_req_idx];
            end
        end
    end

    // One register per word so each can carry its own power-up value; reset
    // deliberately does not touch them.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [WIDTH-1:0] r_word = (INIT_MODE == 0) ? WIDTH'(g * 4) : '0;

        always_ff @(posedge Clk) begin
            if (w_wr_en && (w_load_idx == IDX_BITS'(g))) begin
                r_word <= LoadData;
            end
        end

        assign w_mem[g] = r_word;
    end

    // Response FIFO. The count covers every accepted but not yet delivered
    // fetch, so it is also the outstanding-request counter.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_count   <= 2'd0;
            r_head    <= 1'b0;
            r_fault   <= 2'b00;
            r_data[0] <= '0;
            r_data[1] <= '0;
        end else begin
            if (w_accept) begin
                r_data[w_tail]  <= w_rd_data;
                r_fault[w_tail] <= !w_req_ok;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
        end
    end

    // No credit is taken from a same-cycle response handshake.
    assign ReqReady    = Rst && (r_count != 2'd2);
    assign RespValid   = (r_count != 2'd0);
    assign Instruction = RespValid ? r_data[r_head] : '0;
    assign AddrFault   = RespValid && r_fault[r_head];

endmodule

// File: tb/tb_instruction_fetch_memory.sv
module tb_instruction_fetch_memory;

    localparam int DEPTH    = 128;
    localparam int WIDTH    = 32;
    localparam int IDX_BITS = $clog2(DEPTH);

    logic             Clk;
    logic             Rst;
    logic             ReqValid;
    logic             ReqReady;
    logic [31:0]      Address;
    logic             RespValid;
    logic             RespReady;
    logic [WIDTH-1:0] Instruction;
    logic             AddrFault;
    logic             LoadEn;
    logic [31:0]      LoadAddr;
    logic [WIDTH-1:0] LoadData;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain word array plus an ordered queue of promised responses.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             fault;
    } resp_t;

    logic [WIDTH-1:0] mdl_mem [DEPTH];
    resp_t            mdl_q [$];

    instruction_fetch_memory #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .INIT_MODE(0)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .Address    (Address),
        .RespValid  (RespValid),
        .RespReady  (RespReady),
        .Instruction(Instruction),
        .AddrFault  (AddrFault),
        .LoadEn     (LoadEn),
        .LoadAddr   (LoadAddr),
        .LoadData   (LoadData)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        if (sel == 1) return 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
        if (sel == 2) return 32'h8000_0000 | (32'($urandom) & 32'hFFFF_FFFC);
        return 32'($urandom_range(0, DEPTH - 1)) << 2;
    endfunction

    task automatic set_in(input bit rv, input logic [31:0] addr, input bit rr,
                          input bit le, input logic [31:0] la, input logic [WIDTH-1:0] ld);
        ReqValid  = rv;
        Address   = addr;
        RespReady = rr;
        LoadEn    = le;
        LoadAddr  = la;
        LoadData  = ld;
    endtask

    // Apply the current inputs to the model, then move to the next falling edge.
    task automatic advance();
        bit    acc;
        bit    hs;
        resp_t r;
        if (!Rst) begin
            mdl_q.delete();
        end else begin
            acc = ReqValid && (mdl_q.size() < 2);
            hs  = RespReady && (mdl_q.size() != 0);
            if (hs) void'(mdl_q.pop_front());
            if (LoadEn && addr_ok(LoadAddr)) mdl_mem[LoadAddr[IDX_BITS+1:2]] = LoadData;
            if (acc) begin
                if (addr_ok(Address)) r = '{data: mdl_mem[Address[IDX_BITS+1:2]], fault: 1'b0};
                else                  r = '{data: '0, fault: 1'b1};
                mdl_q.push_back(r);
            end
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        set_in(1'b1, 32'h4, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF);
        advance();
        advance();
        #1;
        n_cmp++; if (RespValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", RespValid); end
        n_cmp++; if (Instruction !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 00000000", Instruction); end
        n_cmp++; if (AddrFault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", AddrFault); end
        n_cmp++; if (ReqReady !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b want 0", ReqReady); end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        Rst = 1'b1;
        #1;
        n_cmp++; if (ReqReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready_release: got %b want 1", ReqReady); end
        advance();
    endtask

    task automatic test_basic_read();
        // Word 4 also confirms the load issued during reset was ignored.
        set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", RespValid); end
        n_cmp++; if (Instruction !== 32'h10) begin n_bad++; $display("FAIL basic_instr: got %h want 00000010", Instruction); end
        n_cmp++; if (AddrFault !== 1'b0) begin n_bad++; $display("FAIL basic_fault: got %b want 0", AddrFault); end
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: got %b want 0", RespValid); end
    endtask

    task automatic test_faults();
        set_in(1'b1, 32'h6, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b1) begin n_bad++; $display("FAIL misalign_valid: got %b want 1", RespValid); end
        n_cmp++; if (Instruction !== 32'h0) begin n_bad++; $display("FAIL misalign_instr: got %h want 00000000", Instruction); end
        n_cmp++; if (AddrFault !== 1'b1) begin n_bad++; $display("FAIL misalign_fault: got %b want 1", AddrFault); end
        set_in(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b1) begin n_bad++; $display("FAIL range_valid: got %b want 1", RespValid); end
        n_cmp++; if (Instruction !== 32'h0) begin n_bad++; $display("FAIL range_instr: got %h want 00000000", Instruction); end
        n_cmp++; if (AddrFault !== 1'b1) begin n_bad++; $display("FAIL range_fault: got %b want 1", AddrFault); end
        // Last legal word must not fault.
        set_in(1'b1, 32'(DEPTH - 1) << 2, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (AddrFault !== 1'b0 || Instruction !== (32'(DEPTH - 1) << 2)) begin
            n_bad++; $display("FAIL last_word: got %h/%b want %h/0", Instruction, AddrFault, 32'(DEPTH - 1) << 2); end
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b0) begin n_bad++; $display("FAIL fault_drain: got %b want 0", RespValid); end
    endtask

    task automatic test_backpressure();
        set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        advance();
        set_in(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, '0);
        #1;
        n_cmp++; if (ReqReady !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one: got %b want 1", ReqReady); end
        advance();
        set_in(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, '0);
        #1;
        n_cmp++; if (ReqReady !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", ReqReady); end
        advance();
        n_cmp++; if (ReqReady !== 1'b0 || RespValid !== 1'b1 || Instruction !== 32'h0 || AddrFault !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold: got rdy=%b vld=%b instr=%h flt=%b want 0 1 00000000 0", ReqReady, RespValid, Instruction, AddrFault); end
        set_in(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b1 || Instruction !== 32'h4) begin
            n_bad++; $display("FAIL bp_second: got vld=%b instr=%h want 1 00000004", RespValid, Instruction); end
        n_cmp++; if (ReqReady !== 1'b1) begin n_bad++; $display("FAIL bp_ready_freed: got %b want 1", ReqReady); end
        advance();
        n_cmp++; if (RespValid !== 1'b1 || Instruction !== 32'h8) begin
            n_bad++; $display("FAIL bp_third: got vld=%b instr=%h want 1 00000008", RespValid, Instruction); end
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", RespValid); end
    endtask

    task automatic test_load_bypass();
        set_in(1'b1, 32'hC, 1'b1, 1'b1, 32'hC, 32'h2008_000A);
        advance();
        n_cmp++; if (Instruction !== 32'h2008_000A) begin n_bad++; $display("FAIL bypass_instr: got %h want 2008000a", Instruction); end
        // Misaligned and out-of-range loads alias word 3 in the index bits but must be dropped.
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'hD, 32'hDEAD_0001);
        advance();
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h20C, 32'hDEAD_0002);
        advance();
        set_in(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (Instruction !== 32'h2008_000A) begin n_bad++; $display("FAIL load_persist: got %h want 2008000a", Instruction); end
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        advance();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        advance();
        set_in(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, '0);
        advance();
        Rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 32'h1111_1111);
        advance();
        n_cmp++; if (RespValid !== 1'b0 || Instruction !== 32'h0) begin
            n_bad++; $display("FAIL midrst_clear: got vld=%b instr=%h want 0 00000000", RespValid, Instruction); end
        Rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        #1;
        n_cmp++; if (ReqReady !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", ReqReady); end
        for (int i = 0; i < 3; i++) begin
            advance();
            n_cmp++; if (RespValid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: cycle %0d got %b want 0", i, RespValid); end
        end
        set_in(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b1 || Instruction !== 32'h2008_000A) begin
            n_bad++; $display("FAIL midrst_mem: got vld=%b instr=%h want 1 2008000a", RespValid, Instruction); end
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, '0);
        advance();
        for (int i = 0; i < 10; i++) begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            set_in(1'b1, a, 1'b1, 1'b0, 32'h0, '0);
            #1;
            n_cmp++; if (ReqReady !== 1'b1 || RespValid !== 1'b1 || Instruction !== mdl_q[0].data) begin
                n_bad++; $display("FAIL b2b_cycle%0d: got rdy=%b vld=%b instr=%h want 1 1 %h", i, ReqReady, RespValid, Instruction, mdl_q[0].data); end
            advance();
        end
        n_cmp++; if (ReqReady !== 1'b1 || RespValid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_end: got rdy=%b vld=%b want 1 1", ReqReady, RespValid); end
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
        advance();
        n_cmp++; if (RespValid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", RespValid); end
    endtask

    task automatic test_random();
        bit exp_vld;
        bit exp_rdy;
        for (int i = 0; i < 600; i++) begin
            Rst = ($urandom_range(0, 99) >= 3);
            set_in($urandom_range(0, 99) < 60, rand_addr(), $urandom_range(0, 99) < 55,
                   $urandom_range(0, 99) < 20, rand_addr(), 32'($urandom));
            #1;
            exp_vld = (mdl_q.size() != 0);
            exp_rdy = Rst && (mdl_q.size() < 2);
            n_cmp++; if (RespValid !== exp_vld || ReqReady !== exp_rdy) begin
                n_bad++; $display("FAIL rand_hs cycle %0d: got vld=%b rdy=%b want %b %b", i, RespValid, ReqReady, exp_vld, exp_rdy); end
            if (exp_vld) begin
                n_cmp++; if (Instruction !== mdl_q[0].data || AddrFault !== mdl_q[0].fault) begin
                    n_bad++; $display("FAIL rand_resp cycle %0d: got %h/%b want %h/%b", i, Instruction, AddrFault, mdl_q[0].data, mdl_q[0].fault); end
            end
            advance();
        end
        Rst = 1'b1;
    endtask

    initial begin
        Rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = WIDTH'(i * 4);
        @(negedge Clk);
        test_reset();
        test_basic_read();
        test_faults();
        test_backpressure();
        test_load_bypass();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_memory.md
INSTRUCTION_FETCH_MEMORY -- requirements
Module: instruction_fetch_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning the number of instruction words stored.
REQ-002 SHALL have parameter WIDTH, default 32, meaning the instruction word width in bits.
REQ-003 SHALL have parameter INIT_MODE, default 0, meaning power-up contents: 0 = word i holds i*4; 1 = all words 0 (NOP).
REQ-004 SHALL derive IDX_BITS = clog2(DEPTH) locally, not overridable.
REQ-005 SHALL have port Clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port Rst, input, 1, a synchronous active-low reset.
REQ-007 SHALL have port ReqValid, input, 1, meaning a fetch request is present.
REQ-008 SHALL have port ReqReady, output, 1, meaning a request can be accepted this cycle.
REQ-009 SHALL have port Address, input, 32, the byte address of the fetch.
REQ-010 SHALL have port RespValid, output, 1, meaning the response is present.
REQ-011 SHALL have port RespReady, input, 1, meaning the consumer takes the response.
REQ-012 SHALL have port Instruction, output, WIDTH, the fetched word.
REQ-013 SHALL have port AddrFault, output, 1, meaning the response belongs to an illegal address.
REQ-014 SHALL have port LoadEn, input, 1, the program-load write strobe.
REQ-015 SHALL have port LoadAddr, input, 32, the program-load byte address.
REQ-016 SHALL have port LoadData, input, WIDTH, the program-load word.

Function
REQ-017 SHALL accept a request in any cycle where ReqValid && ReqReady are both high; a response transfers when RespValid && RespReady are both high.
REQ-018 SHALL index memory with Address[IDX_BITS+1:2]; bits [1:0] never select bytes.
REQ-019 SHALL flag a fault when Address[1:0] != 0, or when Address[31:2] >= DEPTH; a faulting response carries Instruction = 0 and AddrFault = 1.
REQ-020 SHALL perform a registered read: a request accepted in cycle N with an empty response path gives RespValid = 1 in cycle N+1.
REQ-021 SHALL buffer up to 2 outstanding responses (counting in-flight and queued) in a 2-entry FIFO, returned in request order.
REQ-022 SHALL drive ReqReady = (outstanding < 2), with no same-cycle credit from a response handshake.
REQ-023 SHALL keep outstanding unchanged on a simultaneous accept and response handshake; it increments on accept only and decrements on handshake only.
REQ-024 SHALL hold Instruction and AddrFault stable while RespValid = 1 and RespReady = 0.
REQ-025 SHALL write LoadData into word LoadAddr[IDX_BITS+1:2] at the clock edge when LoadEn = 1, provided LoadAddr is aligned and in range; otherwise the write is silently dropped.
REQ-026 SHALL return LoadData (write-first bypass) when a load and an accepted request target the same word in the same cycle.
REQ-027 SHALL apply LoadEn independently of the handshake; loads are never back-pressured.

Reset
REQ-028 SHALL, while Rst = 0 at a clock edge, clear outstanding and the FIFO and set RespValid = 0, Instruction = 0, AddrFault = 0.
REQ-029 SHALL hold ReqReady = 0 while Rst = 0, and set ReqReady = 1 in the first cycle after Rst returns to 1.
REQ-030 SHALL discard requests in flight when reset asserts mid-operation; no stale response appears after reset.
REQ-031 SHALL leave memory contents unchanged on reset; contents are set only by INIT_MODE at time zero and by loads.
REQ-032 SHALL ignore LoadEn while Rst = 0.

Verification
REQ-033 SHALL check: INIT_MODE=0, Address=0x00000010, RespReady=1 -> next cycle RespValid=1, Instruction=0x00000010, AddrFault=0.
REQ-034 SHALL check: Address=0x00000006, then Address=0x00000200 (DEPTH=128) -> two responses, each with Instruction=0 and AddrFault=1.
REQ-035 SHALL check: RespReady=0, ReqValid held for addresses 0x0, 0x4, 0x8 -> only 0x0 and 0x4 are accepted, ReqReady=0; after RespReady=1, the responses are 0x0, 0x4, then 0x8 is accepted, all in order.
REQ-036 SHALL check: LoadEn=1, LoadAddr=0x0C, LoadData=0x2008000A in the same cycle as a request to 0x0C -> response 0x2008000A; a later read of 0x0C returns 0x2008000A.
REQ-037 SHALL check: two requests outstanding, then Rst=0 for 1 cycle -> RespValid=0, Instruction=0; no response for the discarded requests; ReqReady=1 after release; memory word 3 still reads 0x2008000A.
REQ-038 SHALL check: simultaneous accept and response handshake at outstanding=1 for 10 cycles -> outstanding stays 1 and ReqReady stays 1.
